seg7_scan_driver: RTL and testbench

Two-digit multiplexed 7-segment display driver that sits directly downstream of the binary-to-BCD converter. It accepts the converter's `tens`/`ones` BCD nibbles, holds them in a shadow register, and time-multiplexes them onto a common-anode two-digit display. A refresh prescaler and a blanking gap between digits suppress ghosting, and the tens digit supports optional leading-zero blanking.

---
 rtl/seg7_pkg.sv | 34 +++
 rtl/bcd_to_seg7.sv | 17 +
 rtl/seg7_scan_driver.sv | 137 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and segment patterns for the multiplexed 7-segment display driver.
// Segment vectors are active-low and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

   typedef enum logic [1:0] {
      S_GAP0 = 2'd0,
      S_ONES = 2'd1,
      S_GAP1 = 2'd2,
      S_TENS = 2'd3
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Nibbles 10-15 are not BCD. They show a dash so bad upstream data is visible.
   function automatic logic [6:0] digit_pattern(input logic [3:0] digit);
      logic [6:0] pattern;
      case (digit)
         4'd0:    pattern = 7'h40;
         4'd1:    pattern = 7'h79;
         4'd2:    pattern = 7'h24;
         4'd3:    pattern = 7'h30;
         4'd4:    pattern = 7'h19;
         4'd5:    pattern = 7'h12;
         4'd6:    pattern = 7'h02;
         4'd7:    pattern = 7'h78;
         4'd8:    pattern = 7'h00;
         4'd9:    pattern = 7'h10;
         default: pattern = SEG_DASH;
      endcase
      return pattern;
   endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Nibbles 10-15 produce a dash (segment g only).
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (bcd <= 4'd9) begin
         seg = digit_pattern(bcd);
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit common-anode scan driver. It shows the ones digit, then a gap, then the tens digit, then a gap.
// The shown value is latched at gap entry, so a lit digit never changes while it is on.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int DWELL_CYCLES = 50000,
   parameter int GAP_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] tens,
   input  logic [3:0] ones,
   input  logic       load,
   input  logic       blank_lz,
   output logic [1:0] an,
   output logic [6:0] seg,
   output logic       frame_tick
);

   localparam int MAX_LIMIT = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
   localparam int CNT_W     = $clog2(MAX_LIMIT + 1);
   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

   state_t           state_q, state_d, next_slot;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_last;
   logic             slot_done, enter_gap;
   logic [3:0]       sh_tens_q, sh_tens_d, sh_ones_q, sh_ones_d;
   logic [3:0]       dp_tens_q, dp_tens_d, dp_ones_q, dp_ones_d;
   logic [1:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;
   logic             frame_tick_q, frame_tick_d;
   logic [3:0]       dec_in;
   logic [6:0]       dec_seg;

   // Sequencing and counter. The >= compare forces an advance instead of a wrap.
   always_comb begin
      cnt_last = DWELL_LAST;
      if (state_q == S_GAP0 || state_q == S_GAP1) begin
         cnt_last = GAP_LAST;
      end
      slot_done = (cnt_q >= cnt_last);

      next_slot = S_GAP0;
      case (state_q)
         S_GAP0:  next_slot = S_ONES;
         S_ONES:  next_slot = S_GAP1;
         S_GAP1:  next_slot = S_TENS;
         S_TENS:  next_slot = S_GAP0;
         default: next_slot = S_GAP0;
      endcase

      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      if (slot_done) begin
         state_d = next_slot;
         cnt_d   = '0;
      end
      enter_gap = slot_done && (state_q == S_ONES || state_q == S_TENS);
   end

   // Shadow and display registers. A load on the gap-entry edge bypasses the shadow.
   always_comb begin
      sh_tens_d = sh_tens_q;
      sh_ones_d = sh_ones_q;
      if (load) begin
         sh_tens_d = tens;
         sh_ones_d = ones;
      end

      dp_tens_d = dp_tens_q;
      dp_ones_d = dp_ones_q;
      if (enter_gap) begin
         dp_tens_d = sh_tens_d;
         dp_ones_d = sh_ones_d;
      end
   end

   assign dec_in = (state_d == S_TENS) ? dp_tens_d : dp_ones_d;

   bcd_to_seg7 u_dec (
      .bcd (dec_in),
      .seg (dec_seg)
   );

   // Outputs are computed from the next state so they line up with the state register.
   always_comb begin
      an_d  = 2'b11;
      seg_d = SEG_BLANK;
      case (state_d)
         S_ONES: begin
            an_d  = 2'b10;
            seg_d = dec_seg;
         end
         S_TENS: begin
            if (!(blank_lz && dp_tens_d == 4'd0)) begin
               an_d  = 2'b01;
               seg_d = dec_seg;
            end
         end
         default: begin
            an_d  = 2'b11;
            seg_d = SEG_BLANK;
         end
      endcase
      frame_tick_d = (state_d == S_ONES) && (state_q != S_ONES);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_GAP0;
         cnt_q        <= '0;
         sh_tens_q    <= 4'd0;
         sh_ones_q    <= 4'd0;
         dp_tens_q    <= 4'd0;
         dp_ones_q    <= 4'd0;
         an_q         <= 2'b11;
         seg_q        <= SEG_BLANK;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sh_tens_q    <= sh_tens_d;
         sh_ones_q    <= sh_ones_d;
         dp_tens_q    <= dp_tens_d;
         dp_ones_q    <= dp_ones_d;
         an_q         <= an_d;
         seg_q        <= seg_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver with DWELL_CYCLES=4 and GAP_CYCLES=1.
// Each queue entry is the expected {an, seg, frame_tick} for one clock edge.
module tb_seg7_scan_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] tens;
   logic [3:0] ones;
   logic       load;
   logic       blank_lz;
   logic [1:0] an;
   logic [6:0] seg;
   logic       frame_tick;

   logic [9:0] exp_q[$];
   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   always #5 clk = ~clk;

   seg7_scan_driver #(
      .DWELL_CYCLES (4),
      .GAP_CYCLES   (1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .tens       (tens),
      .ones       (ones),
      .load       (load),
      .blank_lz   (blank_lz),
      .an         (an),
      .seg        (seg),
      .frame_tick (frame_tick)
   );

   task automatic push_n(input logic [1:0] a, input logic [6:0] s, input logic first_ft, input int n);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({a, s, (i == 0) ? first_ft : 1'b0});
      end
   endtask

   // One frame: ones slot (4), gap (1), tens slot (4), gap (1).
   task automatic push_frame(input logic [6:0] ones_seg, input logic [1:0] tens_an, input logic [6:0] tens_seg);
      push_n(2'b10, ones_seg, 1'b1, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(tens_an, tens_seg, 1'b0, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
   endtask

   task automatic run(input int n, input string tag);
      logic [9:0] obs;
      logic [9:0] exp_v;
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         cyc++;
         obs = {an, seg, frame_tick};
         tests_run++;
         if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s: cycle %0d observed %h but no expected entry queued", tag, cyc, obs);
         end else begin
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
               tests_failed++;
               $error("FAIL %s: cycle %0d an/seg/ft observed %b/%h/%b expected %b/%h/%b",
                      tag, cyc, obs[9:8], obs[7:1], obs[0], exp_v[9:8], exp_v[7:1], exp_v[0]);
            end
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      tens     = 4'd0;
      ones     = 4'd0;
      load     = 1'b0;
      blank_lz = 1'b0;

      // Reset state, then idle frame showing 0 / 0
      push_n(2'b11, 7'h7F, 1'b0, 2);
      run(2, "reset_state");
      reset = 1'b0;
      push_frame(7'h40, 2'b01, 7'h40);
      run(10, "idle_frame");

      // Load 27 while in the ones slot
      push_n(2'b10, 7'h40, 1'b1, 1);
      run(1, "ones_pre_load");
      load = 1'b1; tens = 4'd2; ones = 4'd7;
      push_n(2'b10, 7'h40, 1'b0, 1);
      run(1, "ones_at_load");
      load = 1'b0;
      push_n(2'b10, 7'h40, 1'b0, 2);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(2'b01, 7'h24, 1'b0, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(8, "load27_tens");
      push_frame(7'h78, 2'b01, 7'h24);
      run(10, "load27_frame");

      // Load 31 on the exact edge entering the gap before tens
      push_n(2'b10, 7'h78, 1'b1, 4);
      run(4, "pre_bypass_ones");
      load = 1'b1; tens = 4'd3; ones = 4'd1;
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(1, "gap1_entry_load");
      load = 1'b0;
      push_n(2'b01, 7'h30, 1'b0, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(5, "bypass_tens");
      push_frame(7'h79, 2'b01, 7'h30);
      run(10, "load31_frame");

      // Reset mid-tens, with a competing load that must lose
      push_n(2'b10, 7'h79, 1'b1, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(2'b01, 7'h30, 1'b0, 2);
      run(7, "pre_reset");
      reset = 1'b1; load = 1'b1; tens = 4'd9; ones = 4'd9;
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(1, "reset_mid_tens");
      reset = 1'b0; load = 1'b0;
      push_frame(7'h40, 2'b01, 7'h40);
      run(10, "after_reset");

      // Leading-zero blanking with 05
      blank_lz = 1'b1; load = 1'b1; tens = 4'd0; ones = 4'd5;
      push_n(2'b10, 7'h40, 1'b1, 1);
      run(1, "blz_load");
      load = 1'b0;
      push_n(2'b10, 7'h40, 1'b0, 3);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(2'b11, 7'h7F, 1'b0, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(9, "blz_tens_blank");
      push_frame(7'h12, 2'b11, 7'h7F);
      run(10, "blz_frame");
      blank_lz = 1'b0;
      push_frame(7'h12, 2'b01, 7'h40);
      run(10, "no_blz_frame");

      // blank_lz raised mid tens slot takes effect on the next edge
      push_n(2'b10, 7'h12, 1'b1, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(2'b01, 7'h40, 1'b0, 2);
      run(7, "blz_live_pre");
      blank_lz = 1'b1;
      push_n(2'b11, 7'h7F, 1'b0, 3);
      run(3, "blz_live");

      // Non-BCD nibbles show a dash
      blank_lz = 1'b0; load = 1'b1; tens = 4'hC; ones = 4'hF;
      push_n(2'b10, 7'h12, 1'b1, 1);
      run(1, "dash_load");
      load = 1'b0;
      push_n(2'b10, 7'h12, 1'b0, 3);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(2'b01, 7'h3F, 1'b0, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(9, "dash_tens");
      push_frame(7'h3F, 2'b01, 7'h3F);
      run(10, "dash_frame");

      // Back-to-back loads: only the last before gap entry (69) is shown
      push_n(2'b10, 7'h3F, 1'b1, 2);
      run(2, "b2b_pre");
      load = 1'b1; tens = 4'd4; ones = 4'd4;
      push_n(2'b10, 7'h3F, 1'b0, 1);
      run(1, "b2b_first");
      tens = 4'd6; ones = 4'd9;
      push_n(2'b10, 7'h3F, 1'b0, 1);
      run(1, "b2b_second");
      load = 1'b0;
      push_n(2'b11, 7'h7F, 1'b0, 1);
      push_n(2'b01, 7'h02, 1'b0, 4);
      push_n(2'b11, 7'h7F, 1'b0, 1);
      run(6, "b2b_tens");
      push_frame(7'h10, 2'b01, 7'h02);
      run(10, "b2b_frame");

      tests_run++;
      if (exp_q.size() != 0) begin
         tests_failed++;
         $display("FAIL queue_drain: observed %0d entries left, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
